// File: rtl/debug_pkg.sv
// Shared types and constants for the debug controller: FSM states, register map, command codes.
// Latency/backpressure: n/a (definitions only).
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        HALTED = 3'd2,
        STEP   = 3'd3,
        XFER   = 3'd4
    } dbg_state_e;

    localparam int REG_CTRL      = 0;
    localparam int REG_ADDR      = 1;
    localparam int REG_WDATA     = 2;
    localparam int REG_RDATA     = 3;
    localparam int REG_STATUS    = 4;
    localparam int REG_STEP_TGT  = 5;
    localparam int REG_STEP_CNT  = 6;
    localparam int REG_BKPT_BASE = 8;

    localparam logic [2:0] CMD_RD_EXT   = 3'b001;
    localparam logic [2:0] CMD_RD_INSTR = 3'b010;
    localparam logic [2:0] CMD_LOCAL_A  = 3'b011;
    localparam logic [2:0] CMD_LOCAL_B  = 3'b100;
    localparam logic [2:0] CMD_WR_A     = 3'b101;
    localparam logic [2:0] CMD_WR_B     = 3'b110;

    localparam int CTRL_DBG_EN     = 0;
    localparam int CTRL_HALT_REQ   = 1;
    localparam int CTRL_GO         = 2;
    localparam int CTRL_STEP_MODE  = 3;
    localparam int CTRL_CMD_LSB    = 4;
    localparam int CTRL_XFER_START = 7;
    localparam int CTRL_CLR        = 8;

    localparam int STAT_XFER_DONE = 0;
    localparam int STAT_XFER_ERR  = 1;
    localparam int STAT_BKPT_HIT  = 2;

    function automatic logic is_xfer_cmd(input logic [2:0] cmd);
        return cmd inside {CMD_RD_EXT, CMD_RD_INSTR, CMD_WR_A, CMD_WR_B};
    endfunction

endpackage

// File: rtl/debug_bkpt_match.sv
// PC breakpoint comparators with lowest-index priority encoding.
// Latency: combinational. Backpressure: none.
module debug_bkpt_match
    import debug_pkg::*;
#(
    parameter int NUM_BKPT = 4
) (
    input  logic [30:0] pc_hw,
    input  logic [31:0] bkpt [NUM_BKPT],
    output logic        hit,
    output logic [7:0]  idx
);

    // Scan downwards so the lowest matching comparator is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_BKPT - 1; i >= 0; i--) begin
            if (bkpt[i][0] && (bkpt[i][31:1] == pc_hw)) begin
                hit = 1'b1;
                idx = 8'(i);
            end
        end
    end

endmodule

// File: rtl/debug_ctrl_bp.sv
// Debug controller: Avalon-MM registers driving pipeline enables, breakpoints, stepping, bridged transfers.
// Latency: reads return one cycle after read&chipselect; FSM acts on CTRL one cycle after the write.
// Backpressure: none on the slave; a bridged transfer holds tx_flag until its ack or the timeout.
module debug_ctrl_bp
    import debug_pkg::*;
#(
    parameter int NUM_BKPT     = 4,
    parameter int NUM_STAGES   = 4,
    parameter int STEP_W       = 16,
    parameter int XFER_TIMEOUT = 1024,
    parameter int ADDR_W       = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  chipselect_debug,
    input  logic                  write_debug,
    input  logic                  read_debug,
    input  logic [ADDR_W-1:0]     adress_debug,
    input  logic [31:0]           writedata_debug,
    output logic [31:0]           readdata_debug,
    input  logic [31:0]           pc,
    input  logic                  enableStep,
    output logic                  debug,
    output logic                  enable_pc_ext,
    output logic [NUM_STAGES-1:0] enable_ext,
    output logic [NUM_STAGES-1:0] clr_ext,
    output logic [2:0]            mode,
    output logic                  tx_flag,
    output logic [31:0]           address_bridged,
    output logic [31:0]           data_bridged,
    input  logic [31:0]           data_internal,
    input  logic                  doneSending,
    input  logic                  doneInstr,
    input  logic                  doneExt
);

    localparam int XCNT_W = $clog2(XFER_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_ADDR     = ADDR_W'(REG_ADDR);
    localparam logic [ADDR_W-1:0] A_WDATA    = ADDR_W'(REG_WDATA);
    localparam logic [ADDR_W-1:0] A_RDATA    = ADDR_W'(REG_RDATA);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_STEP_TGT = ADDR_W'(REG_STEP_TGT);
    localparam logic [ADDR_W-1:0] A_STEP_CNT = ADDR_W'(REG_STEP_CNT);

    dbg_state_e        state_q, state_d;
    logic [8:0]        ctrl;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [31:0]       bkpt [NUM_BKPT];
    logic [STEP_W-1:0] step_tgt, step_cnt, step_cnt_nxt;
    logic [XCNT_W-1:0] xfer_cnt;
    logic [2:0]        xfer_cmd;
    logic              xfer_done, xfer_err, bkpt_hit;
    logic [7:0]        hit_idx, match_idx;
    logic              match_hit, bkpt_take, xfer_ack, xfer_ok, xfer_to;
    logic              wr_en, rd_en;
    logic [31:0]       rd_mux;

    wire       dbg_en     = ctrl[CTRL_DBG_EN];
    wire [2:0] ctrl_cmd   = ctrl[CTRL_CMD_LSB +: 3];

    assign wr_en           = chipselect_debug & write_debug;
    assign rd_en           = chipselect_debug & read_debug;
    assign debug           = dbg_en;
    assign clr_ext         = ctrl[CTRL_CLR] ? '1 : '0;
    assign address_bridged = addr_q;
    assign data_bridged    = wdata_q;

    debug_bkpt_match #(.NUM_BKPT(NUM_BKPT)) u_bkpt_match (
        .pc_hw (pc[31:1]),
        .bkpt  (bkpt),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    assign bkpt_take    = dbg_en && enableStep && match_hit && (state_q == RUN || state_q == STEP);
    assign step_cnt_nxt = (enableStep && step_cnt != '1) ? step_cnt + STEP_W'(1) : step_cnt;

    always_comb begin
        case (xfer_cmd)
            CMD_RD_EXT:   xfer_ack = doneExt;
            CMD_RD_INSTR: xfer_ack = doneInstr;
            default:      xfer_ack = doneSending;
        endcase
    end

    // Losing dbg_en aborts a transfer silently, so completion/timeout are gated by it.
    assign xfer_ok = dbg_en && (state_q == XFER) && xfer_ack;
    assign xfer_to = dbg_en && (state_q == XFER) && !xfer_ack && (xfer_cnt == XCNT_W'(XFER_TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            step_tgt <= '0;
            for (int i = 0; i < NUM_BKPT; i++) bkpt[i] <= '0;
        end else begin
            ctrl[CTRL_GO]         <= 1'b0;
            ctrl[CTRL_XFER_START] <= 1'b0;
            if (wr_en) begin
                case (adress_debug)
                    A_CTRL:     ctrl     <= writedata_debug[8:0];
                    A_ADDR:     addr_q   <= writedata_debug;
                    A_WDATA:    wdata_q  <= writedata_debug;
                    A_STEP_TGT: step_tgt <= writedata_debug[STEP_W-1:0];
                    default: ;
                endcase
                for (int i = 0; i < NUM_BKPT; i++)
                    if (adress_debug == ADDR_W'(REG_BKPT_BASE + i)) bkpt[i] <= writedata_debug;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!dbg_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   state_d = ctrl[CTRL_HALT_REQ] ? HALTED : RUN;
                RUN:    if (bkpt_take || ctrl[CTRL_HALT_REQ]) state_d = HALTED;
                HALTED: begin
                    if (ctrl[CTRL_GO])
                        state_d = ctrl[CTRL_STEP_MODE] ? STEP : RUN;
                    else if (ctrl[CTRL_XFER_START] && is_xfer_cmd(ctrl_cmd))
                        state_d = XFER;
                end
                STEP:   if (bkpt_take || ctrl[CTRL_HALT_REQ] || step_cnt_nxt == step_tgt) state_d = HALTED;
                XFER:   if (xfer_ok || xfer_to) state_d = HALTED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        enable_pc_ext = 1'b1;
        enable_ext    = '1;
        mode          = 3'b000;
        tx_flag       = 1'b0;
        case (state_q)
            HALTED: begin
                enable_pc_ext = 1'b0;
                enable_ext    = '0;
                if (ctrl_cmd == CMD_LOCAL_A || ctrl_cmd == CMD_LOCAL_B) mode = ctrl_cmd;
            end
            XFER: begin
                enable_pc_ext = 1'b0;
                enable_ext    = '0;
                mode          = xfer_cmd;
                tx_flag       = 1'b1;
            end
            default: ;
        endcase
    end

    // Status write-1-clear is applied first so a same-cycle set event overrides it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xfer_done <= 1'b0;
            xfer_err  <= 1'b0;
            bkpt_hit  <= 1'b0;
            hit_idx   <= '0;
            rdata_q   <= '0;
            step_cnt  <= '0;
            xfer_cnt  <= '0;
            xfer_cmd  <= '0;
        end else begin
            if (wr_en && adress_debug == A_STATUS) begin
                if (writedata_debug[STAT_XFER_DONE]) xfer_done <= 1'b0;
                if (writedata_debug[STAT_XFER_ERR])  xfer_err  <= 1'b0;
                if (writedata_debug[STAT_BKPT_HIT])  bkpt_hit  <= 1'b0;
            end
            if (bkpt_take) begin
                bkpt_hit <= 1'b1;
                hit_idx  <= match_idx;
            end
            if (xfer_ok) xfer_done <= 1'b1;
            if (xfer_to) xfer_err  <= 1'b1;
            if (xfer_ok && (xfer_cmd == CMD_RD_EXT || xfer_cmd == CMD_RD_INSTR)) rdata_q <= data_internal;

            if (state_q == IDLE || (state_q == HALTED && state_d == STEP)) step_cnt <= '0;
            else if (state_q == STEP)                                     step_cnt <= step_cnt_nxt;

            if (state_q == XFER) xfer_cnt <= xfer_cnt + XCNT_W'(1);
            else                 xfer_cnt <= '0;
            if (state_q != XFER) xfer_cmd <= ctrl_cmd;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (adress_debug)
            A_CTRL:     rd_mux = {23'd0, ctrl};
            A_ADDR:     rd_mux = addr_q;
            A_WDATA:    rd_mux = wdata_q;
            A_RDATA:    rd_mux = rdata_q;
            A_STATUS:   rd_mux = {16'd0, hit_idx, 1'b0, state_q, 1'b0, bkpt_hit, xfer_err, xfer_done};
            A_STEP_TGT: rd_mux = 32'(step_tgt);
            A_STEP_CNT: rd_mux = 32'(step_cnt);
            default: ;
        endcase
        for (int i = 0; i < NUM_BKPT; i++)
            if (adress_debug == ADDR_W'(REG_BKPT_BASE + i)) rd_mux = bkpt[i];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)        readdata_debug <= '0;
        else if (rd_en) readdata_debug <= rd_mux;
    end

endmodule

// File: tb/tb_debug_ctrl_bp.sv
// Self-checking bench for debug_ctrl_bp: register reads go through an expected-value scoreboard,
// pin-level outputs are checked directly after each stimulus step.
module tb_debug_ctrl_bp;

    localparam int XFER_TIMEOUT = 1024;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        chipselect_debug = 0, write_debug = 0, read_debug = 0;
    logic [3:0]  adress_debug = '0;
    logic [31:0] writedata_debug = '0;
    logic [31:0] readdata_debug;
    logic [31:0] pc = '0;
    logic        enableStep = 0;
    logic        debug, enable_pc_ext, tx_flag;
    logic [3:0]  enable_ext, clr_ext;
    logic [2:0]  mode;
    logic [31:0] address_bridged, data_bridged;
    logic [31:0] data_internal = '0;
    logic        doneSending = 0, doneInstr = 0, doneExt = 0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic        rd_seen = 1'b0;
    logic [31:0] sb_exp;
    string       sb_tag;

    // Reference STATUS contents
    logic       m_done = 0, m_err = 0, m_bkpt = 0;
    logic [7:0] m_idx = '0;

    debug_ctrl_bp #(.XFER_TIMEOUT(XFER_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .chipselect_debug(chipselect_debug), .write_debug(write_debug), .read_debug(read_debug),
        .adress_debug(adress_debug), .writedata_debug(writedata_debug), .readdata_debug(readdata_debug),
        .pc(pc), .enableStep(enableStep), .debug(debug), .enable_pc_ext(enable_pc_ext),
        .enable_ext(enable_ext), .clr_ext(clr_ext), .mode(mode), .tx_flag(tx_flag),
        .address_bridged(address_bridged), .data_bridged(data_bridged), .data_internal(data_internal),
        .doneSending(doneSending), .doneInstr(doneInstr), .doneExt(doneExt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] status_word(input logic [2:0] st);
        return {16'd0, m_idx, 1'b0, st, 1'b0, m_bkpt, m_err, m_done};
    endfunction

    always @(posedge CLK) rd_seen <= chipselect_debug && read_debug;

    always @(negedge CLK) begin
        if (rd_seen && exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            sb_tag = tag_q.pop_front();
            chk(sb_tag, readdata_debug, sb_exp);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic avm_write(input logic [3:0] a, input logic [31:0] d);
        chipselect_debug = 1; write_debug = 1; adress_debug = a; writedata_debug = d;
        @(negedge CLK);
        chipselect_debug = 0; write_debug = 0;
    endtask

    task automatic avm_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        chipselect_debug = 1; read_debug = 1; adress_debug = a;
        @(negedge CLK);
        chipselect_debug = 0; read_debug = 0;
    endtask

    task automatic pulse_step(input logic [31:0] p);
        pc = p; enableStep = 1;
        tick(1);
        enableStep = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int txc;
        tick(3);
        chk("rst_tx_flag", tx_flag, 0);
        chk("rst_enable", enable_ext, 4'hF);
        RST = 0;
        tick(1);
        chk("rst_debug", debug, 0);
        chk("rst_enable_pc", enable_pc_ext, 1);
        chk("rst_clr", clr_ext, 0);
        chk("rst_mode", mode, 0);
        avm_read(4, 32'h0, "rst_status");
        avm_read(0, 32'h0, "rst_ctrl");

        // Breakpoints: [1] same PC but disabled, [2] and [3] both match -> index 2 wins
        avm_write(0, 32'h3);
        avm_write(10, 32'h101);
        avm_write(11, 32'h101);
        avm_write(9, 32'h100);
        chk("halt_enable", enable_ext, 4'h0);
        avm_read(4, status_word(3'd2), "halt_status");
        avm_write(0, 32'h5);
        tick(1);
        chk("run_enable", enable_ext, 4'hF);
        chk("run_debug", debug, 1);
        pulse_step(32'h104);
        chk("bkpt_nomatch", enable_ext, 4'hF);
        pulse_step(32'h100);
        chk("bkpt_enable", enable_ext, 4'h0);
        chk("bkpt_enable_pc", enable_pc_ext, 0);
        m_bkpt = 1; m_idx = 8'd2;
        avm_read(4, status_word(3'd2), "bkpt_status");
        avm_write(4, 32'h4);
        m_bkpt = 0;
        avm_read(4, status_word(3'd2), "w1c_status");

        // Stepping with target 3, then target 0
        pc = 32'h200;
        avm_write(5, 32'd3);
        avm_write(0, 32'hD);
        tick(1);
        chk("step_enter", enable_ext, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            pulse_step(32'h200);
            chk($sformatf("step_pulse%0d", k), enable_ext, (k < 3) ? 4'hF : 4'h0);
            tick(1);
        end
        avm_read(6, 32'd3, "step_count");
        avm_read(5, 32'd3, "step_target");
        avm_write(5, 32'd0);
        avm_write(0, 32'hD);
        tick(1);
        chk("step0_enter", enable_ext, 4'hF);
        tick(1);
        chk("step0_halt", enable_ext, 4'h0);
        avm_read(6, 32'd0, "step0_count");

        // Bridged external read, wrong acks ignored
        avm_write(1, 32'h40);
        chk("addr_bridged", address_bridged, 32'h40);
        avm_write(2, 32'h12345678);
        chk("data_bridged", data_bridged, 32'h12345678);
        data_internal = 32'h0BADF00D;
        avm_write(0, 32'h91);
        tick(1);
        chk("xrd_tx", tx_flag, 1);
        chk("xrd_mode", mode, 3'b001);
        chk("xrd_enable", enable_ext, 4'h0);
        doneSending = 1; tick(1); doneSending = 0;
        doneInstr = 1; tick(1); doneInstr = 0;
        chk("xrd_wrong_ack", tx_flag, 1);
        tick(1);
        data_internal = 32'hDEADBEEF; doneExt = 1;
        tick(1);
        doneExt = 0; data_internal = 32'h0;
        chk("xrd_tx_drop", tx_flag, 0);
        m_done = 1;
        avm_read(3, 32'hDEADBEEF, "xrd_rdata");
        avm_read(4, status_word(3'd2), "xrd_status");

        // Write transfer with no ack -> timeout
        avm_write(0, 32'hE1);
        txc = 0;
        for (int i = 0; i < XFER_TIMEOUT + 50; i++) begin
            @(negedge CLK);
            if (tx_flag) txc++;
            else if (txc > 0) break;
        end
        chk("to_length", txc, XFER_TIMEOUT);
        chk("to_tx", tx_flag, 0);
        chk("to_mode", mode, 0);
        m_err = 1;
        avm_read(4, status_word(3'd2), "to_status");
        avm_read(3, 32'hDEADBEEF, "to_rdata_kept");

        // Abort by clearing dbg_en; CTRL write is seen by the FSM one cycle later
        avm_write(4, 32'h1);
        m_done = 0;
        avm_write(0, 32'hE1);
        tick(1);
        chk("ab_tx", tx_flag, 1);
        chk("ab_mode", mode, 3'b110);
        tick(2);
        avm_write(0, 32'h60);
        chk("ab_prewrite_tx", tx_flag, 1);
        tick(1);
        chk("ab_tx_drop", tx_flag, 0);
        chk("ab_idle_enable", enable_ext, 4'hF);
        avm_read(4, status_word(3'd0), "ab_status");

        // Self-clearing bits, clr, unmapped addresses
        avm_write(0, 32'h184);
        tick(1);
        avm_read(0, 32'h100, "ctrl_selfclr");
        chk("clr_on", clr_ext, 4'hF);
        avm_write(7, 32'hFFFF);
        avm_read(7, 32'h0, "unmapped7");
        avm_read(12, 32'h0, "unmapped_bkpt4");
        avm_read(10, 32'h101, "bkpt2_read");
        avm_write(0, 32'h0);
        chk("clr_off", clr_ext, 4'h0);

        // Asynchronous reset in the middle of a transfer
        avm_write(0, 32'h3);
        tick(1);
        avm_write(0, 32'hE1);
        tick(1);
        chk("rx_tx", tx_flag, 1);
        #2 RST = 1;
        #1 chk("rst_async_tx", tx_flag, 0);
        @(negedge CLK);
        RST = 0;
        m_err = 0; m_idx = '0;
        tick(2);
        chk("rx_after_tx", tx_flag, 0);
        chk("rx_after_enable", enable_ext, 4'hF);
        avm_read(4, status_word(3'd0), "rx_status");
        avm_read(2, 32'h0, "rx_wdata");

        tick(2);
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
